// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, write-to-read bypass,
// a per-register pending-write scoreboard and a background bulk-clear sequencer.
module regfile_scoreboard #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] Read_Register1,
    input  logic [ADDR_WIDTH-1:0] Read_Register2,
    output logic [DATA_WIDTH-1:0] Read_Data1,
    output logic [DATA_WIDTH-1:0] Read_Data2,
    output logic                  Busy1,
    output logic                  Busy2,
    input  logic                  Reg_Write,
    input  logic [ADDR_WIDTH-1:0] Write_Register,
    input  logic [DATA_WIDTH-1:0] Write_Data,
    input  logic                  Reserve,
    input  logic [ADDR_WIDTH-1:0] Reserve_Register,
    input  logic                  Clear,
    output logic                  Clear_Busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastIdx = {ADDR_WIDTH{1'b1}};
    localparam logic [DEPTH-1:0] OneHot0 = {{(DEPTH - 1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DEPTH-1:0]        pending_q, pending_d;

    logic                    idle;
    logic                    wr_en;
    logic                    res_en;
    logic                    byp1, byp2;
    logic                    zero1, zero2;
    logic [DEPTH-1:0]        wr_dec, res_dec, clr_dec;

    function automatic logic writable(input logic [ADDR_WIDTH-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    assign idle   = (state_q == StIdle);
    assign wr_en  = idle && Reg_Write && writable(Write_Register);
    assign res_en = idle && Reserve && writable(Reserve_Register);

    assign byp1  = wr_en && (Write_Register == Read_Register1);
    assign byp2  = wr_en && (Write_Register == Read_Register2);
    assign zero1 = !writable(Read_Register1);
    assign zero2 = !writable(Read_Register2);

    always_comb begin
        Read_Data1 = mem_q[Read_Register1];
        Read_Data2 = mem_q[Read_Register2];
        if (zero1) begin
            Read_Data1 = '0;
        end else if (byp1) begin
            Read_Data1 = Write_Data;
        end
        if (zero2) begin
            Read_Data2 = '0;
        end else if (byp2) begin
            Read_Data2 = Write_Data;
        end
    end

    // Clearing forces a stall on both ports, even for the zero register.
    always_comb begin
        Busy1 = pending_q[Read_Register1];
        Busy2 = pending_q[Read_Register2];
        if (!idle) begin
            Busy1 = 1'b1;
            Busy2 = 1'b1;
        end else begin
            if (zero1 || byp1) Busy1 = 1'b0;
            if (zero2 || byp2) Busy2 = 1'b0;
        end
    end

    assign Clear_Busy = !idle;

    always_comb begin
        wr_dec  = wr_en ? (OneHot0 << Write_Register) : '0;
        res_dec = res_en ? (OneHot0 << Reserve_Register) : '0;
        clr_dec = idle ? '0 : (OneHot0 << cnt_q);
        // A same-edge reserve is the newer producer, so it wins over the write's clear.
        pending_d = ((pending_q & ~wr_dec) | res_dec) & ~clr_dec;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (Clear) begin
                    state_d = StClear;
                    cnt_d   = '0;
                end
            end
            StClear: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (clr_dec[i]) begin
                    mem_q[i] <= '0;
                end else if (wr_dec[i]) begin
                    mem_q[i] <= Write_Data;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: behavioural register-file model compared every cycle, plus directed
// literal checks and a small-parameter instance.
module tb_regfile_scoreboard;

    logic        Clock;
    logic        Reset_n;
    logic [4:0]  Read_Register1, Read_Register2;
    logic [31:0] Read_Data1, Read_Data2;
    logic        Busy1, Busy2;
    logic        Reg_Write;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic        Reserve;
    logic [4:0]  Reserve_Register;
    logic        Clear;
    logic        Clear_Busy;

    logic [2:0]  s_rr1, s_rr2, s_wa, s_ra;
    logic [15:0] s_rd1, s_rd2, s_wd;
    logic        s_busy1, s_busy2, s_we, s_res, s_clear, s_clear_busy;

    int checks = 0;
    int errors = 0;

    regfile_scoreboard u_dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .Read_Register1  (Read_Register1),
        .Read_Register2  (Read_Register2),
        .Read_Data1      (Read_Data1),
        .Read_Data2      (Read_Data2),
        .Busy1           (Busy1),
        .Busy2           (Busy2),
        .Reg_Write       (Reg_Write),
        .Write_Register  (Write_Register),
        .Write_Data      (Write_Data),
        .Reserve         (Reserve),
        .Reserve_Register(Reserve_Register),
        .Clear           (Clear),
        .Clear_Busy      (Clear_Busy)
    );

    regfile_scoreboard #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(3),
        .ZERO_REG  (0)
    ) u_small (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .Read_Register1  (s_rr1),
        .Read_Register2  (s_rr2),
        .Read_Data1      (s_rd1),
        .Read_Data2      (s_rd2),
        .Busy1           (s_busy1),
        .Busy2           (s_busy2),
        .Reg_Write       (s_we),
        .Write_Register  (s_wa),
        .Write_Data      (s_wd),
        .Reserve         (s_res),
        .Reserve_Register(s_ra),
        .Clear           (s_clear),
        .Clear_Busy      (s_clear_busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural model: plain arrays plus a "clearing" flag and next index to zero.
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_clearing;
    int          m_next;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_clearing = 1'b0;
        m_next     = 0;
    endtask

    task automatic model_step();
        if (m_clearing) begin
            m_mem[m_next]  = '0;
            m_pend[m_next] = 1'b0;
            m_next++;
            if (m_next == 32) m_clearing = 1'b0;
        end else begin
            if (Reg_Write && Write_Register != 0) begin
                m_mem[Write_Register]  = Write_Data;
                m_pend[Write_Register] = 1'b0;
            end
            if (Reserve && Reserve_Register != 0) m_pend[Reserve_Register] = 1'b1;
            if (Clear) begin
                m_clearing = 1'b1;
                m_next     = 0;
            end
        end
    endtask

    function automatic logic [31:0] exp_data(input logic [4:0] a);
        if (m_clearing) return m_mem[a];
        if (a == 0) return 32'h0;
        if (Reg_Write && Write_Register == a) return Write_Data;
        return m_mem[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [4:0] a);
        if (m_clearing) return 32'd1;
        if (a == 0) return 32'd0;
        if (Reg_Write && Write_Register == a) return 32'd0;
        return {31'b0, m_pend[a]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge Clock or negedge Reset_n);
            if (!Reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge Clock);
            chk("cmp_rd1", Read_Data1, exp_data(Read_Register1));
            chk("cmp_rd2", Read_Data2, exp_data(Read_Register2));
            chk("cmp_busy1", {31'b0, Busy1}, exp_busy(Read_Register1));
            chk("cmp_busy2", {31'b0, Busy2}, exp_busy(Read_Register2));
            chk("cmp_clear_busy", {31'b0, Clear_Busy}, {31'b0, m_clearing});
        end
    end

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        Reg_Write = 1'b0;
        Reserve   = 1'b0;
        Clear     = 1'b0;
    endtask

    int n;

    initial begin
        Reset_n = 1'b0;
        idle_inputs();
        Read_Register1 = '0; Read_Register2 = '0;
        Write_Register = '0; Write_Data = '0; Reserve_Register = '0;
        s_rr1 = '0; s_rr2 = '0; s_wa = '0; s_ra = '0; s_wd = '0;
        s_we = 1'b0; s_res = 1'b0; s_clear = 1'b0;
        repeat (2) cyc();
        Reset_n = 1'b1;
        Read_Register1 = 5'd5;
        #1;
        chk("reset_rd1", Read_Data1, 32'h0);
        chk("reset_busy1", {31'b0, Busy1}, 32'h0);
        chk("reset_clear_busy", {31'b0, Clear_Busy}, 32'h0);

        // Small instance: r0 is ordinary and the clear takes 8 cycles.
        s_we = 1'b1; s_wa = 3'd0; s_wd = 16'h00FF;
        cyc();
        s_we = 1'b0;
        #1;
        chk("small_r0", {16'h0, s_rd1}, 32'h00FF);
        s_clear = 1'b1;
        cyc();
        s_clear = 1'b0;
        n = 0;
        while (s_clear_busy && n < 50) begin
            n++;
            cyc();
        end
        chk("small_clear_len", n, 32'd8);
        chk("small_r0_cleared", {16'h0, s_rd1}, 32'h0);

        // Basic write/read.
        Reg_Write = 1'b1; Write_Register = 5'd5; Write_Data = 32'hDEADBEEF;
        cyc();
        idle_inputs();
        Read_Register1 = 5'd5; Read_Register2 = 5'd5;
        #1;
        chk("r5_port1", Read_Data1, 32'hDEADBEEF);
        chk("r5_port2", Read_Data2, 32'hDEADBEEF);
        Read_Register2 = 5'd6;
        #1;
        chk("r6_port2", Read_Data2, 32'h0);

        // Zero register and bypass.
        cyc();
        Reg_Write = 1'b1; Write_Register = 5'd0; Write_Data = 32'h1234; Read_Register1 = 5'd0;
        #1;
        chk("r0_no_bypass", Read_Data1, 32'h0);
        cyc();
        idle_inputs();
        #1;
        chk("r0_after_write", Read_Data1, 32'h0);
        Reg_Write = 1'b1; Write_Register = 5'd7; Write_Data = 32'hA5A5; Read_Register1 = 5'd7;
        #1;
        chk("bypass_r7", Read_Data1, 32'hA5A5);
        cyc();
        idle_inputs();

        // Scoreboard.
        Reserve = 1'b1; Reserve_Register = 5'd9; Read_Register1 = 5'd9;
        #1;
        chk("r9_busy_before", {31'b0, Busy1}, 32'h0);
        cyc();
        Reserve = 1'b0;
        #1;
        chk("r9_busy_after_reserve", {31'b0, Busy1}, 32'h1);
        Reg_Write = 1'b1; Write_Register = 5'd9; Write_Data = 32'h99;
        #1;
        chk("r9_busy_write_cycle", {31'b0, Busy1}, 32'h0);
        cyc();
        idle_inputs();
        #1;
        chk("r9_busy_after_write", {31'b0, Busy1}, 32'h0);
        chk("r9_data", Read_Data1, 32'h99);
        Reserve = 1'b1; Reserve_Register = 5'd9;
        Reg_Write = 1'b1; Write_Register = 5'd9; Write_Data = 32'h77;
        cyc();
        idle_inputs();
        #1;
        chk("r9_busy_res_and_write", {31'b0, Busy1}, 32'h1);
        chk("r9_data_res_and_write", Read_Data1, 32'h77);

        // Bulk clear over a full file.
        for (int i = 1; i < 32; i++) begin
            Reg_Write = 1'b1; Write_Register = 5'(i); Write_Data = 32'h01010101 * i;
            cyc();
        end
        idle_inputs();
        Reserve = 1'b1; Reserve_Register = 5'd3;
        cyc();
        idle_inputs();
        Read_Register1 = 5'd3;
        #1;
        chk("r3_busy_pre_clear", {31'b0, Busy1}, 32'h1);
        chk("r3_data_pre_clear", Read_Data1, 32'h03030303);
        Clear = 1'b1;
        cyc();
        Clear = 1'b0;
        n = 0;
        while (Clear_Busy && n < 100) begin
            n++;
            idle_inputs();
            if (n == 5) begin
                Reg_Write = 1'b1; Write_Register = 5'd4; Write_Data = 32'hBAD;
            end
            if (n == 10) Clear = 1'b1;
            if (n == 12) begin
                Reserve = 1'b1; Reserve_Register = 5'd20;
            end
            Read_Register1 = 5'($urandom);
            Read_Register2 = 5'($urandom);
            cyc();
        end
        idle_inputs();
        chk("clear_len", n, 32'd32);
        for (int i = 0; i < 32; i++) begin
            Read_Register1 = 5'(i);
            Read_Register2 = 5'(31 - i);
            #1;
            chk("post_clear_rd1", Read_Data1, 32'h0);
            chk("post_clear_busy1", {31'b0, Busy1}, 32'h0);
            chk("post_clear_rd2", Read_Data2, 32'h0);
            chk("post_clear_busy2", {31'b0, Busy2}, 32'h0);
            cyc();
        end

        // Reset during a clear.
        Reg_Write = 1'b1; Write_Register = 5'd12; Write_Data = 32'h00C0FFEE;
        cyc();
        idle_inputs();
        Reserve = 1'b1; Reserve_Register = 5'd13;
        cyc();
        idle_inputs();
        Clear = 1'b1;
        cyc();
        Clear = 1'b0;
        repeat (10) cyc();
        Read_Register1 = 5'd12; Read_Register2 = 5'd13;
        #1;
        chk("midclear_r12_kept", Read_Data1, 32'h00C0FFEE);
        @(posedge Clock);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_clear_busy", {31'b0, Clear_Busy}, 32'h0);
        chk("async_rd1", Read_Data1, 32'h0);
        chk("async_busy2", {31'b0, Busy2}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            cyc();
            Read_Register1 = 5'(i);
            #1;
            chk("in_reset_rd1", Read_Data1, 32'h0);
        end
        cyc();
        Reset_n = 1'b1;
        Reg_Write = 1'b1; Write_Register = 5'd12; Write_Data = 32'h5555;
        cyc();
        idle_inputs();
        Read_Register1 = 5'd12;
        #1;
        chk("post_reset_write", Read_Data1, 32'h5555);

        // Randomised traffic checked by the per-cycle compare.
        repeat (3000) begin
            cyc();
            Reg_Write        = 1'($urandom_range(0, 1));
            Write_Register   = 5'($urandom);
            Write_Data       = $urandom;
            Reserve          = ($urandom_range(0, 3) == 0);
            Reserve_Register = 5'($urandom);
            Clear            = ($urandom_range(0, 99) == 0);
            Read_Register1   = 5'($urandom);
            Read_Register2   = 5'($urandom);
            if ($urandom_range(0, 3) == 0) Read_Register1 = Write_Register;
            if ($urandom_range(0, 3) == 0) Read_Register2 = Reserve_Register;
        end
        cyc();
        idle_inputs();
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the single-cycle/pipelined datapath: two asynchronous read ports, one synchronous write port, register 0 hardwired to zero, and same-cycle write-to-read bypass. Also holds a per-register pending-write scoreboard, so the control unit can detect RAW hazards on multi-cycle producers such as loads. A bulk-clear sequencer zeroes the whole file in the background. It sits between instruction decode (addresses, reservations) and the ALU/writeback stages.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, address width; DEPTH = 2**ADDR_WIDTH registers
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations; 0 = ordinary register

- Clock  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Read_Register1, Read_Register2  in  ADDR_WIDTH  read addresses
- Read_Data1, Read_Data2  out  DATA_WIDTH  read data
- Busy1, Busy2  out  1  pending-write flag for the addressed register
- Reg_Write  in  1  write enable
- Write_Register  in  ADDR_WIDTH  write address
- Write_Data  in  DATA_WIDTH  write data
- Reserve  in  1  mark a register as awaiting a future write
- Reserve_Register  in  ADDR_WIDTH  register to reserve
- Clear  in  1  start a bulk clear (single-cycle pulse or level)
- Clear_Busy  out  1  bulk clear in progress

## Operation
- Reset (Reset_n=0, asynchronous): all registers 0, all pending bits 0, FSM IDLE, clear counter 0. Outputs: Read_DataN=0, BusyN=0, Clear_Busy=0.
- Read (combinational): Read_DataN = mem[Read_RegisterN]. Bypass: if Reg_Write=1, Write_Register==Read_RegisterN, and the address is writable, Read_DataN = Write_Data.
- Zero register (ZERO_REG=1): address 0 always reads 0 and BusyN=0. A write or reserve to address 0 is a no-op.
- Write: on the rising edge with Reg_Write=1 in IDLE, mem[Write_Register] <= Write_Data and pending[Write_Register] <= 0.
- Reserve: on the rising edge with Reserve=1 in IDLE, pending[Reserve_Register] <= 1.
- Reserve and write to the same register on the same edge: data is written and pending ends at 1, because the reserve is a newer producer.
- BusyN = pending[Read_RegisterN], except BusyN=0 when a bypassing write to that address is present this cycle.
- Clear FSM, two states:
  - IDLE: Clear=1 -> CLEAR, counter <= 0.
  - CLEAR: each edge, mem[counter] <= 0, pending[counter] <= 0, counter++.
  - When counter == DEPTH-1, write the last entry and return to IDLE.
- During CLEAR:
  - Clear_Busy=1 and Busy1=Busy2=1, so the pipeline must stall.
  - Reg_Write and Reserve are ignored, and there is no bypass.
  - Clear is ignored; it does not restart the sequence.
  - Read_DataN returns current storage, which may be partially cleared.
- Reset asserted mid-clear aborts immediately to the reset state.

## Timing
- Read latency 0 cycles, combinational from address and bypass inputs.
- Write visible through bypass in the same cycle, and from storage from the next cycle.
- Pending bit set by Reserve is visible on BusyN the cycle after the edge.
- Bulk clear takes exactly DEPTH cycles (32 by default). Clear_Busy rises on the edge that samples Clear=1 and falls on the edge that clears entry DEPTH-1.
- The first Reg_Write/Reserve is accepted on the edge after Clear_Busy falls.
- Counter is ADDR_WIDTH bits wide; wrap from DEPTH-1 to 0 coincides with the return to IDLE.

## Test plan
- Reset then basic write/read: write 0xDEADBEEF to r5, then read r5 on both ports next cycle -> 0xDEADBEEF. Reading r6 -> 0.
- Zero register and bypass: write 0x1234 to r0 -> reads 0. With Reg_Write=1, Write_Register=7, Write_Data=0xA5A5, Read_Register1=7 in the same cycle -> Read_Data1=0xA5A5 before the edge.
- Scoreboard:
  - Reserve r9 -> Busy1=1 from the next cycle while Read_Register1=9.
  - Write r9 -> Busy1=0 in the write cycle, and pending stays clear after.
  - Simultaneous reserve and write on r9 -> Busy1=1 afterwards, and data is updated.
- Bulk clear: fill r1..r31 with non-zero values and reserve r3, then pulse Clear.
  - Clear_Busy=1 for exactly 32 cycles, with Busy1=Busy2=1 throughout.
  - A Reg_Write to r4 during the clear is ignored.
  - After the clear, every register reads 0 and every BusyN=0.
- Reset mid-clear: assert Reset_n=0 at clear cycle 10 -> Clear_Busy=0, all registers 0 and no pending bits immediately (asynchronous). A new write is accepted after Reset_n rises.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3, ZERO_REG=0 -> r0 is writable (0x00FF reads back), and the clear takes 8 cycles.
